window_stddev: RTL

- Computes the standard deviation of the current detection window, used by the classifier to normalise feature thresholds (featureThreshold * stddev).
- Consumes four corner beats, each carrying an integral-image word and a squared-integral-image word.
- Forms sum and sqsum, computes var = AREA*sqsum - sum^2, clamped at 0, then an iterative integer square root.
- Presents the result on a valid/ready stream that connects directly to the classifier's stddev port.

---
 rtl/window_stddev.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/window_stddev.sv
`timescale 1ns/1ps
// window_stddev: standard deviation of a detection window from four
// integral-image corner beats. It accumulates sum/sqsum with a +,-,+,- corner
// pattern and forms var = AREA*sqsum - sum^2, clamped to [0, 2^W_VAR-1].
// A restoring square root then produces one bit per cycle, and the root is
// presented on a valid/ready stream.
module window_stddev #(
  parameter int W_DATA      = 18,
  parameter int W_SQDATA    = 26,
  parameter int WINDOW_AREA = 529,
  parameter int W_STDDEV    = 36
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [W_DATA-1:0]   din_ii,
  input  logic [W_SQDATA-1:0] din_sii,
  output logic                stddev_valid,
  input  logic                stddev_ready,
  output logic [W_STDDEV-1:0] stddev_data
);

  localparam int W_AREA  = $clog2(WINDOW_AREA + 1);
  localparam int W_VAR   = W_SQDATA + W_AREA + 1;
  localparam int W_ROOT  = (W_VAR + 1) / 2;
  localparam int W_SUM   = W_DATA + 2;
  localparam int W_SQSUM = W_SQDATA + 2;
  localparam int W_PROD  = W_VAR + W_DATA + 4;
  localparam int W_RAD   = 2 * W_ROOT;
  localparam int W_REM   = W_ROOT + 3;
  localparam int W_IDX   = (W_ROOT > 1) ? $clog2(W_ROOT) : 1;

  localparam logic signed [W_PROD-1:0] AREA_S  = W_PROD'(WINDOW_AREA);
  localparam logic signed [W_PROD-1:0] VAR_MAX =
    {{(W_PROD - W_VAR){1'b0}}, {W_VAR{1'b1}}};

  typedef enum logic [2:0] {IDLE, ACC, MUL, SQRT, OUT} state_t;

  state_t                    state;
  logic [1:0]                beat_cnt;
  logic signed [W_SUM-1:0]   sum;
  logic signed [W_SQSUM-1:0] sqsum;
  logic [W_RAD-1:0]          rad;
  logic [W_REM-1:0]          rem;
  logic [W_ROOT-1:0]         root;
  logic [W_IDX-1:0]          idx;
  logic                      sqrt_done;

  logic signed [W_SUM-1:0]   ii_ext;
  logic signed [W_SQSUM-1:0] sii_ext;
  logic signed [W_PROD-1:0]  sum_x;
  logic signed [W_PROD-1:0]  sqsum_x;
  logic signed [W_PROD-1:0]  var_full;
  logic [W_REM-1:0]          rem_shift;
  logic [W_REM-1:0]          trial;
  logic                      take;
  logic [W_REM-1:0]          rem_next;
  logic [W_ROOT-1:0]         root_next;
  logic                      accept;

  // Negative variance (or a garbage negative sqsum) maps to 0; values above
  // the radicand range pin to all-ones.
  function automatic logic [W_VAR-1:0] clamp_var(
    input logic signed [W_PROD-1:0] v,
    input logic                     sq_neg
  );
    if (sq_neg || (v < 0))
      return '0;
    else if (v > VAR_MAX)
      return {W_VAR{1'b1}};
    else
      return v[W_VAR-1:0];
  endfunction

  // Operand extension, variance arithmetic and one restoring-root step.
  always_comb begin
    accept    = din_valid & din_ready;
    ii_ext    = {2'b00, din_ii};
    sii_ext   = {2'b00, din_sii};
    sum_x     = {{(W_PROD - W_SUM){sum[W_SUM-1]}}, sum};
    sqsum_x   = {{(W_PROD - W_SQSUM){sqsum[W_SQSUM-1]}}, sqsum};
    var_full  = AREA_S * sqsum_x - sum_x * sum_x;
    rem_shift = (rem << 2) | W_REM'(rad[W_RAD-1 -: 2]);
    trial     = {1'b0, root, 2'b01};
    take      = (rem_shift >= trial);
    rem_next  = take ? (rem_shift - trial) : rem_shift;
    root_next = {root[W_ROOT-2:0], take};
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      sum          <= '0;
      sqsum        <= '0;
      rad          <= '0;
      rem          <= '0;
      root         <= '0;
      idx          <= '0;
      sqrt_done    <= 1'b0;
      din_ready    <= 1'b0;
      stddev_valid <= 1'b0;
      stddev_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          din_ready <= 1'b1;
          if (accept) begin
            sum      <= ii_ext;
            sqsum    <= sii_ext;
            beat_cnt <= 2'd1;
            state    <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            if (beat_cnt[0]) begin
              sum   <= sum - ii_ext;
              sqsum <= sqsum - sii_ext;
            end else begin
              sum   <= sum + ii_ext;
              sqsum <= sqsum + sii_ext;
            end
            if (beat_cnt == 2'd3) begin
              beat_cnt  <= '0;
              din_ready <= 1'b0;
              state     <= MUL;
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
            end
          end
        end
        MUL: begin
          rad       <= W_RAD'(clamp_var(var_full, sqsum[W_SQSUM-1]));
          rem       <= '0;
          root      <= '0;
          idx       <= W_IDX'(W_ROOT - 1);
          sqrt_done <= 1'b0;
          state     <= SQRT;
        end
        SQRT: begin
          if (!sqrt_done) begin
            rem  <= rem_next;
            root <= root_next;
            rad  <= rad << 2;
            if (idx == '0)
              sqrt_done <= 1'b1;
            else
              idx <= idx - 1'b1;
          end else begin
            stddev_data  <= W_STDDEV'(root);
            stddev_valid <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (stddev_ready) begin
            stddev_valid <= 1'b0;
            din_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          din_ready    <= 1'b0;
          stddev_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
